// File: rtl/csc_row_sched_if.sv
// Handshake bundle between csc_row_sched and the parameter RAM, csc_stor datapath and CSC write port.
// master = scheduler side, slave = the RAM/datapath/storage side.
interface csc_row_sched_if #(
    parameter int ROW_W   = 7,
    parameter int INDEX_W = 8
);
    logic                   prm_rd;
    logic [ROW_W-1:0]       prm_addr;
    logic [223:0]           prm_data;
    logic [255:0]           dp_param;
    logic                   val_vld;
    logic                   val_rdy;
    logic [4*INDEX_W-1:0]   s_col;
    logic [255:0]           s_vals;
    logic                   s_vld;
    logic                   s_rdy;
    logic                   wr_en;
    logic                   wr_rdy;
    logic [ROW_W-1:0]       wr_row;
    logic [INDEX_W-1:0]     wr_col;
    logic [31:0]            wr_re;
    logic [31:0]            wr_im;
    logic                   wr_last;

    modport master (
        output prm_rd, prm_addr, dp_param, val_vld, s_rdy,
               wr_en, wr_row, wr_col, wr_re, wr_im, wr_last,
        input  prm_data, val_rdy, s_col, s_vals, s_vld, wr_rdy
    );
    modport slave (
        input  prm_rd, prm_addr, dp_param, val_vld, s_rdy,
               wr_en, wr_row, wr_col, wr_re, wr_im, wr_last,
        output prm_data, val_rdy, s_col, s_vals, s_vld, wr_rdy
    );
endinterface

// File: rtl/csc_row_sched.sv
// Row sequencer for csc_stor: fetch params, issue, collect S, serialise nonzeros into CSC storage.
// Optional CSC_ZERO_SKIP_EN: drop entries whose re and im are both zero.
module csc_row_sched #(
    parameter int  MAT_RANK = 256,
    parameter int  ROWS     = 128,
    localparam int INDEX_W  = $clog2(MAT_RANK),
    localparam int ROW_W    = (ROWS > 1) ? $clog2(ROWS) : 1
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               i_start,
    input  logic               i_abort,
    output logic               o_busy,
    output logic               o_done,
    output logic [ROW_W+2:0]   o_nnz_cnt,
    csc_row_sched_if.master    bus
);
`ifdef CSC_ZERO_SKIP_EN
    localparam bit SKIP = 1'b1;
`else
    localparam bit SKIP = 1'b0;
`endif

    typedef enum logic [2:0] {
        S_IDLE, S_FETCH, S_LOAD, S_ISSUE, S_COLLECT, S_WRITE, S_DONE
    } state_t;

    state_t                 r_state;
    logic [ROW_W-1:0]       r_row;
    logic [223:0]           r_param;
    logic                   r_four;
    logic [4*INDEX_W-1:0]   r_col;
    logic [255:0]           r_vals;
    logic [1:0]             r_k;
    logic                   r_prm_rd, r_val_vld, r_s_rdy, r_wr_en, r_busy, r_done;
    logic [ROW_W+2:0]       r_nnz;

    // First entry index >= from that is written; 4 means none left in this row.
    function automatic logic [2:0] find_ent(input logic [255:0] v, input logic four,
                                            input logic [2:0] from);
        logic [2:0] res;
        res = 3'd4;
        for (int k = 3; k >= 0; k--) begin
            if (3'(k) >= from && (four || k < 2) && (!SKIP || v[64*k +: 64] != 64'd0))
                res = 3'(k);
        end
        return res;
    endfunction

    logic [2:0] w_first, w_next;
    logic       w_last_row;

    assign w_first    = find_ent(bus.s_vals, r_four, 3'd0);
    assign w_next     = find_ent(r_vals, r_four, {1'b0, r_k} + 3'd1);
    assign w_last_row = (r_row == ROW_W'(ROWS - 1));

    assign bus.prm_rd   = r_prm_rd;
    assign bus.prm_addr = r_row;
    assign bus.dp_param = {r_param, 32'd0};
    assign bus.val_vld  = r_val_vld;
    assign bus.s_rdy    = r_s_rdy;
    assign bus.wr_en    = r_wr_en;
    assign bus.wr_row   = r_row;
    assign bus.wr_col   = r_col[r_k*INDEX_W +: INDEX_W];
    assign bus.wr_re    = r_vals[64*r_k +: 32];
    assign bus.wr_im    = r_vals[64*r_k + 32 +: 32];
    assign bus.wr_last  = r_wr_en && w_next[2];
    assign o_busy       = r_busy;
    assign o_done       = r_done;
    assign o_nnz_cnt    = r_nnz;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= S_IDLE;
            r_row     <= '0;
            r_param   <= '0;
            r_four    <= 1'b0;
            r_col     <= '0;
            r_vals    <= '0;
            r_k       <= '0;
            r_prm_rd  <= 1'b0;
            r_val_vld <= 1'b0;
            r_s_rdy   <= 1'b0;
            r_wr_en   <= 1'b0;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
            r_nnz     <= '0;
        end else if (i_abort && r_state != S_IDLE) begin
            // The datapath is left as-is; its owner resets it.
            r_state   <= S_IDLE;
            r_prm_rd  <= 1'b0;
            r_val_vld <= 1'b0;
            r_s_rdy   <= 1'b0;
            r_wr_en   <= 1'b0;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                S_IDLE: if (i_start && !i_abort) begin
                    r_busy   <= 1'b1;
                    r_nnz    <= '0;
                    r_row    <= '0;
                    r_prm_rd <= 1'b1;
                    r_state  <= S_FETCH;
                end
                S_FETCH: begin
                    r_prm_rd <= 1'b0;
                    r_state  <= S_LOAD;
                end
                S_LOAD: begin
                    r_param   <= bus.prm_data;
                    r_four    <= (bus.prm_data[223:208] != bus.prm_data[207:192]);
                    r_val_vld <= 1'b1;
                    r_state   <= S_ISSUE;
                end
                S_ISSUE: if (bus.val_rdy) begin
                    r_val_vld <= 1'b0;
                    r_s_rdy   <= 1'b1;
                    r_state   <= S_COLLECT;
                end
                S_COLLECT: if (bus.s_vld) begin
                    r_s_rdy <= 1'b0;
                    r_col   <= bus.s_col;
                    r_vals  <= bus.s_vals;
                    r_k     <= w_first[1:0];
                    r_wr_en <= !w_first[2];
                    r_state <= S_WRITE;
                end
                S_WRITE: begin
                    if (r_wr_en && bus.wr_rdy)
                        r_nnz <= r_nnz + (ROW_W+3)'(1);
                    // Empty row (all skipped) leaves WRITE after one idle cycle.
                    if (!r_wr_en || (bus.wr_rdy && w_next[2])) begin
                        r_wr_en <= 1'b0;
                        if (w_last_row) begin
                            r_done  <= 1'b1;
                            r_state <= S_DONE;
                        end else begin
                            r_row    <= r_row + ROW_W'(1);
                            r_prm_rd <= 1'b1;
                            r_state  <= S_FETCH;
                        end
                    end else if (bus.wr_rdy) begin
                        r_k <= w_next[1:0];
                    end
                end
                S_DONE: begin
                    r_busy  <= 1'b0;
                    r_state <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_csc_row_sched.sv
// Directed bench for csc_row_sched (ROWS=2) with a parameter RAM model, a simple
// datapath model and a write-port monitor.
module tb_csc_row_sched;
    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       start = 1'b0;
    logic       abort = 1'b0;
    logic       busy, done;
    logic [3:0] nnz;
    int         nvec = 0;
    int         nerr = 0;

    csc_row_sched_if #(.ROW_W(1), .INDEX_W(8)) bus ();
    csc_row_sched #(.MAT_RANK(256), .ROWS(2)) dut (
        .clk(clk), .rst_n(rst_n), .i_start(start), .i_abort(abort),
        .o_busy(busy), .o_done(done), .o_nnz_cnt(nnz), .bus(bus)
    );

    always #5 clk = ~clk;

    logic [223:0] prm_mem [2];
    logic [31:0]  re_tab [2][4];
    logic [31:0]  im_tab [2][4];
    int           stall_cfg = 0;
    bit           wtoggle = 1'b0;
    int           vcnt = 0;
    logic [255:0] dp_cap = '0;

    always @(posedge clk) if (bus.prm_rd) bus.prm_data <= prm_mem[bus.prm_addr];

    // Datapath: answers one cycle after accepting parameters.
    logic [15:0]  mz0, mz1;
    logic [255:0] msv;
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) bus.s_vld <= 1'b0;
        else if (abort) bus.s_vld <= 1'b0;
        else if (bus.val_vld && bus.val_rdy) begin
            mz0 = bus.dp_param[255:240];
            mz1 = bus.dp_param[239:224];
            for (int k = 0; k < 4; k++) begin
                msv[64*k +: 32]      = re_tab[bus.prm_addr][k];
                msv[64*k + 32 +: 32] = im_tab[bus.prm_addr][k];
            end
            bus.s_col  <= (mz0 == mz1) ? {8'h0, 8'h0, 8'(mz0 + 16'd128), 8'(mz0)}
                                       : {8'(mz1 + 16'd128), 8'(mz0 + 16'd128), 8'(mz1), 8'(mz0)};
            bus.s_vals <= msv;
            dp_cap     <= bus.dp_param;
            bus.s_vld  <= 1'b1;
        end else if (bus.s_vld && bus.s_rdy) bus.s_vld <= 1'b0;
    end

    always @(negedge clk) begin
        bus.wr_rdy = wtoggle ? ~bus.wr_rdy : 1'b1;
        if (!bus.val_vld) vcnt = stall_cfg;
        else if (vcnt > 0) vcnt--;
        bus.val_rdy = (vcnt == 0);
    end

    // Monitor: logs accepted writes, done pulses, exclusivity and stall-stability errors.
    int         wcnt = 0, done_cnt = 0, stab_err = 0, excl_err = 0;
    logic [9:0] wlog [128];
    logic [31:0] wre [128];
    logic       p_wst = 1'b0, p_vst = 1'b0, p_ab = 1'b0;
    logic [41:0] p_wr;
    logic [255:0] p_dp;
    always @(posedge clk) begin
        if (rst_n) begin
            if (bus.wr_en && bus.wr_rdy) begin
                if (wcnt < 128) begin
                    wlog[wcnt] = {bus.wr_row[0], bus.wr_last, bus.wr_col};
                    wre[wcnt]  = bus.wr_re;
                end
                wcnt++;
            end
            if (done) done_cnt++;
            if (int'(bus.val_vld) + int'(bus.s_rdy) + int'(bus.wr_en) > 1) excl_err++;
            if (p_wst && !p_ab && !(bus.wr_en &&
                {bus.wr_row[0], bus.wr_last, bus.wr_col, bus.wr_re} == p_wr)) stab_err++;
            if (p_vst && !p_ab && !(bus.val_vld && bus.dp_param == p_dp)) stab_err++;
        end
        p_wst = bus.wr_en && !bus.wr_rdy;
        p_wr  = {bus.wr_row[0], bus.wr_last, bus.wr_col, bus.wr_re};
        p_vst = bus.val_vld && !bus.val_rdy;
        p_dp  = bus.dp_param;
        p_ab  = abort;
    end

    task automatic set_rows(input logic [15:0] z0, input logic [15:0] z1);
        for (int r = 0; r < 2; r++) begin
            prm_mem[r] = {z0, z1, 32'(r + 100), 32'h5, 32'h6, 32'h7, 32'h8, 32'(r + 200)};
            for (int k = 0; k < 4; k++) begin
                re_tab[r][k] = 32'(r * 16 + k + 1);
                im_tab[r][k] = 32'(r * 16 + k + 128);
            end
        end
    endtask

    task automatic pulse_start();
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0;
    endtask

    // Returns the cycle index (1 = first cycle after the start edge) at which done is seen.
    task automatic wait_done(output int cyc);
        cyc = 1;
        while (done !== 1'b1 && cyc < 400) begin @(negedge clk); cyc++; end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        nvec++; if ({busy, done, nnz} !== 6'd0) begin nerr++;
            $display("FAIL reset_status: got %0h expected 0", {busy, done, nnz}); end
        nvec++; if ({bus.prm_rd, bus.val_vld, bus.s_rdy, bus.wr_en, bus.wr_last} !== 5'd0) begin nerr++;
            $display("FAIL reset_strobes: got %b expected 00000",
                     {bus.prm_rd, bus.val_vld, bus.s_rdy, bus.wr_en, bus.wr_last}); end
        nvec++; if (bus.dp_param !== 256'd0 || bus.prm_addr !== 1'b0) begin nerr++;
            $display("FAIL reset_param: got %0h expected 0", bus.dp_param); end
    endtask

    task automatic test_basic();
        int cyc, b, d;
        int cols[4] = '{3, 9, 131, 137};
        logic [9:0] e;
        set_rows(16'd3, 16'd9);
        b = wcnt; d = done_cnt;
        pulse_start();
        nvec++; if (busy !== 1'b1) begin nerr++; $display("FAIL basic_busy: got %b expected 1", busy); end
        wait_done(cyc);
        nvec++; if (cyc != 17) begin nerr++; $display("FAIL basic_latency: got %0d expected 17", cyc); end
        repeat (2) @(negedge clk);
        nvec++; if (wcnt - b != 8) begin nerr++; $display("FAIL basic_count: got %0d expected 8", wcnt - b); end
        for (int i = 0; i < 8; i++) begin
            e = {1'(i / 4), i % 4 == 3, 8'(cols[i % 4])};
            nvec++; if (wlog[b + i] !== e) begin nerr++;
                $display("FAIL basic_entry%0d: got %h expected %h", i, wlog[b + i], e); end
            nvec++; if (wre[b + i] !== 32'((i / 4) * 16 + i % 4 + 1)) begin nerr++;
                $display("FAIL basic_re%0d: got %0h expected %0h", i, wre[b + i], (i / 4) * 16 + i % 4 + 1); end
        end
        nvec++; if (nnz !== 4'd8) begin nerr++; $display("FAIL basic_nnz: got %0d expected 8", nnz); end
        nvec++; if (done_cnt - d != 1) begin nerr++; $display("FAIL basic_done: got %0d expected 1", done_cnt - d); end
        nvec++; if (busy !== 1'b0) begin nerr++; $display("FAIL basic_idle: got %b expected 0", busy); end
        nvec++; if (dp_cap !== {prm_mem[1], 32'd0}) begin nerr++;
            $display("FAIL basic_dp_param: got %h expected %h", dp_cap, {prm_mem[1], 32'd0}); end
    endtask

    task automatic test_equal_z();
        int cyc, b;
        logic [9:0] e;
        set_rows(16'd5, 16'd5);
        b = wcnt;
        pulse_start();
        wait_done(cyc);
        nvec++; if (cyc != 13) begin nerr++; $display("FAIL equal_latency: got %0d expected 13", cyc); end
        repeat (2) @(negedge clk);
        nvec++; if (wcnt - b != 4) begin nerr++; $display("FAIL equal_count: got %0d expected 4", wcnt - b); end
        for (int i = 0; i < 4; i++) begin
            e = {1'(i / 2), i % 2 == 1, (i % 2 == 1) ? 8'd133 : 8'd5};
            nvec++; if (wlog[b + i] !== e) begin nerr++;
                $display("FAIL equal_entry%0d: got %h expected %h", i, wlog[b + i], e); end
        end
        nvec++; if (nnz !== 4'd4) begin nerr++; $display("FAIL equal_nnz: got %0d expected 4", nnz); end
    endtask

    task automatic test_backpressure();
        int cyc, b, s;
        int cols[4] = '{3, 9, 131, 137};
        logic [9:0] e;
        set_rows(16'd3, 16'd9);
        b = wcnt; s = stab_err;
        stall_cfg = 5; wtoggle = 1'b1;
        pulse_start();
        wait_done(cyc);
        nvec++; if (cyc >= 400) begin nerr++; $display("FAIL stall_timeout: got %0d expected <400", cyc); end
        repeat (2) @(negedge clk);
        stall_cfg = 0; wtoggle = 1'b0;
        nvec++; if (wcnt - b != 8) begin nerr++; $display("FAIL stall_count: got %0d expected 8", wcnt - b); end
        for (int i = 0; i < 8; i++) begin
            e = {1'(i / 4), i % 4 == 3, 8'(cols[i % 4])};
            nvec++; if (wlog[b + i] !== e) begin nerr++;
                $display("FAIL stall_entry%0d: got %h expected %h", i, wlog[b + i], e); end
        end
        nvec++; if (stab_err - s != 0) begin nerr++; $display("FAIL stall_stable: got %0d expected 0", stab_err - s); end
        nvec++; if (excl_err != 0) begin nerr++; $display("FAIL strobe_exclusive: got %0d expected 0", excl_err); end
        nvec++; if (nnz !== 4'd8) begin nerr++; $display("FAIL stall_nnz: got %0d expected 8", nnz); end
    endtask

    task automatic test_abort();
        int n, b, d;
        set_rows(16'd3, 16'd9);
        b = wcnt; d = done_cnt; n = 0;
        pulse_start();
        while (wcnt - b < 1 && n < 100) begin @(negedge clk); n++; end
        nvec++; if (n >= 100) begin nerr++; $display("FAIL abort_wait: got timeout expected first write"); end
        abort = 1'b1;
        @(negedge clk); abort = 1'b0;
        nvec++; if ({busy, bus.wr_en, bus.val_vld, bus.s_rdy, bus.prm_rd} !== 5'd0) begin nerr++;
            $display("FAIL abort_idle: got %b expected 00000",
                     {busy, bus.wr_en, bus.val_vld, bus.s_rdy, bus.prm_rd}); end
        nvec++; if (nnz !== 4'd1) begin nerr++; $display("FAIL abort_nnz: got %0d expected 1", nnz); end
        repeat (20) @(negedge clk);
        nvec++; if (done_cnt != d || busy !== 1'b0) begin nerr++;
            $display("FAIL abort_no_done: got %0d expected 0", done_cnt - d); end
    endtask

    task automatic test_abort_start();
        @(negedge clk); start = 1'b1; abort = 1'b1;
        @(negedge clk); start = 1'b0; abort = 1'b0;
        nvec++; if (busy !== 1'b0 || bus.prm_rd !== 1'b0) begin nerr++;
            $display("FAIL abort_start_busy: got %b expected 00", {busy, bus.prm_rd}); end
        nvec++; if (nnz !== 4'd1) begin nerr++; $display("FAIL abort_start_nnz: got %0d expected 1", nnz); end
    endtask

    task automatic test_start_while_busy();
        int cyc, b, d, n;
        set_rows(16'd3, 16'd9);
        b = wcnt; d = done_cnt; n = 0;
        pulse_start();
        while (wcnt - b < 5 && n < 100) begin @(negedge clk); n++; end
        start = 1'b1; @(negedge clk); start = 1'b0;
        wait_done(cyc);
        repeat (2) @(negedge clk);
        nvec++; if (wcnt - b != 8) begin nerr++; $display("FAIL busy_start_count: got %0d expected 8", wcnt - b); end
        nvec++; if (nnz !== 4'd8) begin nerr++; $display("FAIL busy_start_nnz: got %0d expected 8", nnz); end
        nvec++; if (done_cnt - d != 1) begin nerr++; $display("FAIL busy_start_done: got %0d expected 1", done_cnt - d); end
    endtask

    task automatic test_zero_skip();
        int cyc, b, exp_n;
        logic [9:0] e [8];
        set_rows(16'd3, 16'd9);
        re_tab[0][1] = 32'd0; im_tab[0][1] = 32'd0;
`ifdef CSC_ZERO_SKIP_EN
        exp_n = 7;
        e = '{{1'b0, 1'b0, 8'd3}, {1'b0, 1'b0, 8'd131}, {1'b0, 1'b1, 8'd137},
              {1'b1, 1'b0, 8'd3}, {1'b1, 1'b0, 8'd9}, {1'b1, 1'b0, 8'd131}, {1'b1, 1'b1, 8'd137}, 10'd0};
`else
        exp_n = 8;
        e = '{{1'b0, 1'b0, 8'd3}, {1'b0, 1'b0, 8'd9}, {1'b0, 1'b0, 8'd131}, {1'b0, 1'b1, 8'd137},
              {1'b1, 1'b0, 8'd3}, {1'b1, 1'b0, 8'd9}, {1'b1, 1'b0, 8'd131}, {1'b1, 1'b1, 8'd137}};
`endif
        b = wcnt;
        pulse_start();
        wait_done(cyc);
        repeat (2) @(negedge clk);
        nvec++; if (wcnt - b != exp_n) begin nerr++;
            $display("FAIL skip_count: got %0d expected %0d", wcnt - b, exp_n); end
        for (int i = 0; i < exp_n; i++) begin
            nvec++; if (wlog[b + i] !== e[i]) begin nerr++;
                $display("FAIL skip_entry%0d: got %h expected %h", i, wlog[b + i], e[i]); end
        end
        nvec++; if (nnz !== 4'(exp_n)) begin nerr++; $display("FAIL skip_nnz: got %0d expected %0d", nnz, exp_n); end
    endtask

    task automatic test_reset_mid_collect();
        int b, d, n;
        set_rows(16'd3, 16'd9);
        b = wcnt; d = done_cnt; n = 0;
        pulse_start();
        while (!(wcnt - b >= 4 && bus.s_rdy === 1'b1) && n < 100) begin @(negedge clk); n++; end
        nvec++; if (n >= 100 || nnz !== 4'd4) begin nerr++;
            $display("FAIL rst_mid_reach: got nnz %0d expected 4 in COLLECT", nnz); end
        rst_n = 1'b0;
        #1;
        nvec++; if ({busy, done, nnz, bus.prm_rd, bus.val_vld, bus.s_rdy, bus.wr_en, bus.wr_last} !== 11'd0) begin
            nerr++; $display("FAIL rst_mid_outputs: got %b expected 0",
                {busy, done, nnz, bus.prm_rd, bus.val_vld, bus.s_rdy, bus.wr_en, bus.wr_last}); end
        nvec++; if ({bus.dp_param, bus.wr_col, bus.wr_re, bus.wr_im, bus.prm_addr} !== '0) begin nerr++;
            $display("FAIL rst_mid_fields: got %h expected 0", bus.dp_param); end
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (20) @(negedge clk);
        nvec++; if (done_cnt != d || busy !== 1'b0) begin nerr++;
            $display("FAIL rst_mid_no_done: got %0d expected 0", done_cnt - d); end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_equal_z();
        test_backpressure();
        test_abort();
        test_abort_start();
        test_start_while_busy();
        test_zero_skip();
        test_reset_mid_collect();
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end
endmodule
